// File: rtl/scan_buffer_ctrl.sv
// Scan acquisition buffer controller: fills one unit per TICK_CYCLES clocks, holds, then drains downstream.
// Optional build macro SCANBUF_AUTO_DRAIN_EN: reaching full in FILL jumps straight to DRAIN.
module scan_buffer_ctrl #(
  parameter  int DEPTH       = 10,
  parameter  int TICK_CYCLES = 8,
  parameter  int TH_A_PCT    = 80,
  parameter  int TH_B_PCT    = 90,
  localparam int LW          = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scan_start,
  input  logic          scan_stop,
  input  logic          xfer_start,
  input  logic          drain_rdy,
  output logic          drain_valid,
  output logic [LW-1:0] level,
  output logic          lvl_a,
  output logic          lvl_b,
  output logic          full,
  output logic          empty,
  output logic [1:0]    state,
  output logic          overflow
);

  localparam int TH_A = DEPTH * TH_A_PCT / 100;
  localparam int TH_B = DEPTH * TH_B_PCT / 100;
  localparam int TW   = $clog2(TICK_CYCLES);

  localparam logic [LW-1:0] DEPTH_L    = LW'(DEPTH);
  localparam logic [LW-1:0] TH_A_L     = LW'(TH_A);
  localparam logic [LW-1:0] TH_B_L     = LW'(TH_B);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e        state_q;
  logic [TW-1:0] tick_q;
  logic [LW-1:0] level_q;
  logic          overflow_q;
  logic          tick_wrap;

  // Handshake: a unit moves downstream on any edge where drain_valid and drain_rdy are both high;
  // drain_valid never depends on drain_rdy.
  assign drain_valid = (state_q == DRAIN) && (level_q != '0);
  assign tick_wrap   = (tick_q == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (scan_start) begin
            state_q    <= FILL;
            tick_q     <= '0;
            overflow_q <= 1'b0;
          end
        end
        FILL: begin
          // A transfer request abandons the in-progress tick rather than counting it.
          if (xfer_start) begin
            state_q <= (level_q != '0) ? DRAIN : IDLE;
          end else begin
            tick_q <= tick_wrap ? '0 : tick_q + TW'(1);
            if (scan_stop) state_q <= HOLD;
`ifdef SCANBUF_AUTO_DRAIN_EN
            if (tick_wrap && (level_q < DEPTH_L)) begin
              level_q <= level_q + LW'(1);
              if (level_q == DEPTH_L - LW'(1)) state_q <= DRAIN;
            end
`else
            if (tick_wrap) begin
              if (level_q < DEPTH_L) level_q <= level_q + LW'(1);
              else                   overflow_q <= 1'b1;
            end
`endif
          end
        end
        HOLD: begin
          if (xfer_start) begin
            state_q <= (level_q != '0) ? DRAIN : IDLE;
          end else if (scan_start) begin
            state_q <= FILL;
            tick_q  <= '0;
          end
        end
        DRAIN: begin
          if (drain_valid && drain_rdy) begin
            level_q <= level_q - LW'(1);
            if (level_q == LW'(1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign level    = level_q;
  assign state    = state_q;
  assign overflow = overflow_q;
  assign empty    = (level_q == '0);
  assign full     = (level_q == DEPTH_L);
  assign lvl_b    = (level_q >= TH_B_L) && (level_q < DEPTH_L);
  assign lvl_a    = (level_q >= TH_A_L) && (level_q < TH_B_L);

endmodule
